// File: rtl/io_pkg.sv
// Shared definitions for the CPU input-port/interrupt peripherals.
package io_pkg;

    localparam int IO_WIDTH = 8;
    localparam int IO_DEPTH = 4;
    localparam int IO_GAP   = 2;

    // Literals carry a prefix so they cannot collide with the GAP parameter.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } io_state_e;

    function automatic int io_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_int_port_if.sv
// Device-side and CPU-side signals of one input-port/interrupt pair.
interface io_int_port_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] ext_data;
    logic             ext_stb;
    logic             ack;
    logic             clr_ovf;
    logic [WIDTH-1:0] iport;
    logic             intPort;
    logic             full;
    logic             overflow;
    logic [CW-1:0]    count;

    modport master (
        output ext_data, ext_stb, ack, clr_ovf,
        input  iport, intPort, full, overflow, count
    );

    modport slave (
        input  ext_data, ext_stb, ack, clr_ovf,
        output iport, intPort, full, overflow, count
    );
endinterface

// File: rtl/io_int_port_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic rise
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = d_async;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/io_int_port.sv
// Captures bytes from an asynchronous device into a FIFO and interrupts the CPU once per byte.
module io_int_port
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH,
    parameter int GAP   = IO_GAP
) (
    input logic         clk,
    input logic         reset,
    io_int_port_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP + 1);

    logic push;
    logic pop;
    logic push_ok;
    logic full_w;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    io_state_e        state_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             irq_q;

    sync_edge u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .d_async (bus.ext_stb),
        .rise    (push)
    );

    assign full_w = (count_q == CW'(DEPTH));
    // Only an interrupt the CPU is actually servicing may retire the head byte.
    assign pop    = bus.ack && (state_q == ST_IRQ || state_q == ST_WAIT) && (count_q != '0);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        push_ok = push && (!full_w || pop);

        if (push_ok) begin
            mem_d[wr_q] = bus.ext_data;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set is evaluated last so it wins over a simultaneous clear.
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push && full_w && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // GAP holds for exactly GAP cycles after the pop before IDLE may re-arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= ST_IRQ;
                        irq_q   <= 1'b1;
                    end
                end
                ST_IRQ: begin
                    if (pop) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= GW'(GAP);
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= GW'(GAP);
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - GW'(1);
                    if (gap_cnt_q <= GW'(1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.iport    = (count_q != '0) ? mem_q[rd_q] : '0;
    assign bus.intPort  = irq_q;
    assign bus.full     = full_w;
    assign bus.overflow = ovf_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_io_int_port.sv
// Directed bench for io_int_port: cycle table for a single byte plus hand sequences for FIFO/FSM corners.
module tb_io_int_port;
    logic clk;
    logic reset;

    io_int_port_if #(.WIDTH(8), .DEPTH(4)) bus();

    io_int_port #(.WIDTH(8), .DEPTH(4), .GAP(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic [7:0] data;
        logic       ack;
        logic       clr;
        logic [2:0] e_count;
        logic [7:0] e_iport;
        logic       e_int;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t       tbl [12];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         last_pulse = -1;
    int         min_gap = 1000;
    logic [7:0] pulse_data [$];
    logic       auto_ack = 1'b0;
    logic       ack_arm = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.intPort) begin
            pulse_cnt++;
            pulse_data.push_back(bus.iport);
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
        if (auto_ack) begin
            bus.ack = ack_arm;
            ack_arm = bus.intPort;
        end
    endtask

    task automatic clear_log();
        pulse_cnt  = 0;
        last_pulse = -1;
        min_gap    = 1000;
        pulse_data.delete();
    endtask

    task automatic do_reset();
        auto_ack     = 1'b0;
        ack_arm      = 1'b0;
        reset        = 1'b0;
        bus.ext_stb  = 1'b0;
        bus.ext_data = 8'h00;
        bus.ack      = 1'b0;
        bus.clr_ovf  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_log();
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.ext_data = d;
        bus.ext_stb  = 1'b1;
        repeat (3) step();
        bus.ext_stb = 1'b0;
        repeat (2) step();
    endtask

    task automatic manual_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic drain(input int want);
        int n;
        n = 0;
        ack_arm  = 1'b0;
        auto_ack = 1'b1;
        while (pulse_cnt < want && n < 80) begin
            step();
            n++;
        end
        repeat (10) step();
        auto_ack = 1'b0;
        bus.ack  = 1'b0;
        chk("drain_bound", (n < 80) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Single byte, applied one clock per row.
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset then idle.
        do_reset();
        chk("rst_outputs", {bus.count, bus.iport, bus.intPort, bus.full, bus.overflow},
            {3'd0, 8'h00, 1'b0, 1'b0, 1'b0});
        repeat (20) step();
        chk("rst_no_pulse", pulse_cnt, 0);

        // Single byte table.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.ext_stb  = tbl[i].stb;
            bus.ext_data = tbl[i].data;
            bus.ack      = tbl[i].ack;
            bus.clr_ovf  = tbl[i].clr;
            step();
            chk($sformatf("single_row%0d", i),
                {bus.count, bus.iport, bus.intPort, bus.full, bus.overflow},
                {tbl[i].e_count, tbl[i].e_iport, tbl[i].e_int, tbl[i].e_full, tbl[i].e_ovf});
        end
        chk("single_pulses", pulse_cnt, 1);

        // Back-to-back with auto ack one cycle after each pulse.
        do_reset();
        ack_arm  = 1'b0;
        auto_ack = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        n = 0;
        while (pulse_cnt < 3 && n < 60) begin
            step();
            n++;
        end
        repeat (10) step();
        auto_ack = 1'b0;
        bus.ack  = 1'b0;
        chk("b2b_pulses", pulse_cnt, 3);
        if (pulse_data.size() == 3)
            chk("b2b_data", {pulse_data[0], pulse_data[1], pulse_data[2]}, {8'h11, 8'h22, 8'h33});
        chk("b2b_spacing", (min_gap >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk("b2b_empty", bus.count, 0);

        // Level held high gives one push; GAP timing; ack in IRQ; ack in IDLE ignored.
        do_reset();
        bus.ext_data = 8'hAA;
        bus.ext_stb  = 1'b1;
        repeat (8) step();
        bus.ext_stb = 1'b0;
        repeat (2) step();
        chk("level_one_push", bus.count, 1);
        push_byte(8'hBB);
        chk("gap_two_queued", bus.count, 2);
        manual_ack();
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.intPort && n < 10);
        chk("gap_pulse_delay", n, 3);
        chk("gap_pulse_head", bus.iport, 8'hBB);
        manual_ack();
        chk("ack_in_irq_pops", bus.count, 0);
        repeat (6) step();
        bus.ext_data = 8'hCC;
        bus.ext_stb  = 1'b1;
        repeat (2) step();
        bus.ack = 1'b1;
        step();
        bus.ack     = 1'b0;
        bus.ext_stb = 1'b0;
        chk("ack_in_idle_ignored", bus.count, 1);
        step();
        chk("cc_pulse", {bus.intPort, bus.iport}, {1'b1, 8'hCC});

        // Overflow: five pushes into four entries.
        do_reset();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        push_byte(8'h05);
        chk("ovf_state", {bus.count, bus.full, bus.overflow, bus.iport},
            {3'd4, 1'b1, 1'b1, 8'h01});
        manual_ack();
        drain(4);
        chk("ovf_pulses", pulse_cnt, 4);
        if (pulse_data.size() == 4)
            chk("ovf_data", {pulse_data[0], pulse_data[1], pulse_data[2], pulse_data[3]},
                {8'h01, 8'h02, 8'h03, 8'h04});
        chk("ovf_drained", {bus.count, bus.iport, bus.overflow}, {3'd0, 8'h00, 1'b1});
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.overflow, 0);

        // Full FIFO with a push landing on the same edge as a pop.
        do_reset();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        bus.ext_data = 8'h99;
        bus.ext_stb  = 1'b1;
        repeat (2) step();
        bus.ack = 1'b1;
        step();
        bus.ack     = 1'b0;
        bus.ext_stb = 1'b0;
        repeat (2) step();
        chk("cpop_state", {bus.count, bus.full, bus.overflow, bus.iport},
            {3'd4, 1'b1, 1'b0, 8'h02});
        clear_log();
        drain(4);
        if (pulse_data.size() == 4)
            chk("cpop_order", {pulse_data[0], pulse_data[1], pulse_data[2], pulse_data[3]},
                {8'h02, 8'h03, 8'h04, 8'h99});
        else
            chk("cpop_pulses", pulse_data.size(), 4);

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        push_byte(8'hAA);
        push_byte(8'hBB);
        chk("mid_queued", bus.count, 2);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_outputs", {bus.count, bus.iport, bus.intPort, bus.full, bus.overflow},
            {3'd0, 8'h00, 1'b0, 1'b0, 1'b0});
        #2;
        reset = 1'b1;
        clear_log();
        manual_ack();
        step();
        chk("mid_ack_ignored", bus.count, 0);
        repeat (10) step();
        chk("mid_no_pulse", pulse_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
